// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the multi-cycle core.
//   opcode_e : 5-bit instruction opcodes (values not listed are illegal)
//   state_e  : sequencer states FETCH / EXEC / MEM / HALTED
//   flags_t  : condition flags packed as {N,C,Z}
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SHL  = 5'd6,
    OP_SHR  = 5'd7,
    OP_LD   = 5'd8,
    OP_ST   = 5'd9,
    OP_JMP  = 5'd10,
    OP_BEQ  = 5'd11,
    OP_HALT = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic n;
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_param.sv
// alu_param: combinational ALU for the multi-cycle core.
//   op_i : opcode (only ADD..SHR produce a result, others give 0)
//   a_i  : first operand, b_i : second operand
//   y_o  : result, c_o : carry (ADD) / borrow (SUB), 0 for logic and shifts
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 19,
  localparam int SH_W  = $clog2(DATA_W)
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              c_o
);

  logic [SH_W-1:0]   shamt_s;
  logic              shift_over_s;
  logic [DATA_W:0]   sum_s;

  assign shamt_s      = b_i[SH_W-1:0];
  // Only the low shift bits count; values at or above the width flush to 0.
  assign shift_over_s = ({1'b0, shamt_s} >= (SH_W+1)'(DATA_W));
  assign sum_s        = {1'b0, a_i} + {1'b0, b_i};

  // Result and carry selection per opcode.
  always_comb begin
    y_o = {DATA_W{1'b0}};
    c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o = sum_s[DATA_W-1:0];
        c_o = sum_s[DATA_W];
      end
      OP_SUB: begin
        y_o = a_i - b_i;
        c_o = (a_i < b_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_SHL: begin
        if (shift_over_s) y_o = {DATA_W{1'b0}};
        else              y_o = a_i << shamt_s;
      end
      OP_SHR: begin
        if (shift_over_s) y_o = {DATA_W{1'b0}};
        else              y_o = a_i >> shamt_s;
      end
      default: begin
        y_o = {DATA_W{1'b0}};
        c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle core with a single shared memory port.
//   clk, reset          : clock and synchronous active-high reset
//   mem_req/we/addr/wdata : memory request, held stable until mem_ready
//   mem_rdata, mem_ready  : read data and request acceptance
//   pc_o, flags_o {N,C,Z} : architectural state
//   halted, illegal       : core stopped (illegal = undefined opcode)
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 19,
  parameter int NUM_REGS = 16,
  parameter int INSTR_W  = 20,
  localparam int REG_AW  = $clog2(NUM_REGS),
  localparam int IMM_W   = INSTR_W - 6 - 2*REG_AW,
  localparam int RD_W    = (DATA_W > INSTR_W) ? DATA_W : INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [RD_W-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        flags_o,
  output logic              halted,
  output logic              illegal
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  flags_t              flags_q, flags_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   rf_d [NUM_REGS];
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  // Instruction fields.
  opcode_e                   opc_s;
  logic                      mode_s;
  logic [REG_AW-1:0]         rd_s, rs1_s, rs2_s;
  logic signed [IMM_W-1:0]   imm_s;
  logic [DATA_W-1:0]         imm_data_s, ra_s, rb_s, rdv_s, op2_s, alu_y_s;
  logic [ADDR_W-1:0]         imm_addr_s, ea_s;
  logic                      alu_c_s;

  assign opc_s      = opcode_e'(ir_q[INSTR_W-1 -: 5]);
  assign mode_s     = ir_q[INSTR_W-6];
  assign rd_s       = ir_q[INSTR_W-7 -: REG_AW];
  assign rs1_s      = ir_q[INSTR_W-7-REG_AW -: REG_AW];
  assign rs2_s      = ir_q[REG_AW-1:0];
  assign imm_s      = $signed(ir_q[IMM_W-1:0]);
  assign imm_data_s = DATA_W'(imm_s);
  assign imm_addr_s = ADDR_W'(imm_s);

  // R0 is hard-wired to zero on every read port.
  assign ra_s  = (rs1_s == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rs1_s];
  assign rb_s  = (rs2_s == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rs2_s];
  assign rdv_s = (rd_s  == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : rf_q[rd_s];
  assign op2_s = mode_s ? imm_data_s : rb_s;
  assign ea_s  = ADDR_W'(ra_s) + imm_addr_s;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .op_i (opc_s),
    .a_i  (ra_s),
    .b_i  (op2_s),
    .y_o  (alu_y_s),
    .c_o  (alu_c_s)
  );

  // Next-state logic for the sequencer and all architectural state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    rf_d      = rf_q;
    maddr_d   = maddr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata[INSTR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1'b1);
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opc_s)
          OP_NOP: state_d = ST_FETCH;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            if (rd_s != {REG_AW{1'b0}}) rf_d[rd_s] = alu_y_s;
            else                        rf_d[rd_s] = {DATA_W{1'b0}};
            flags_d.n = alu_y_s[DATA_W-1];
            flags_d.c = alu_c_s;
            flags_d.z = (alu_y_s == {DATA_W{1'b0}});
          end
          OP_LD, OP_ST: begin
            maddr_d = ea_s;
            we_d    = (opc_s == OP_ST);
            wdata_d = rdv_s;
            state_d = ST_MEM;
          end
          OP_JMP: pc_d = ADDR_W'(ra_s);
          OP_BEQ: begin
            // pc already points past the branch, so the offset is relative to it.
            if (flags_q.z) pc_d = pc_q + imm_addr_s;
            else           pc_d = pc_q;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
          default: begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_HALTED;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (!we_q && (rd_s != {REG_AW{1'b0}})) rf_d[rd_s] = mem_rdata[DATA_W-1:0];
          else                                   rf_d[rd_s] = rf_q[rd_s];
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= {ADDR_W{1'b0}};
      ir_q      <= {INSTR_W{1'b0}};
      flags_q   <= 3'b000;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= {DATA_W{1'b0}};
      maddr_q   <= {ADDR_W{1'b0}};
      we_q      <= 1'b0;
      wdata_q   <= {DATA_W{1'b0}};
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      rf_q      <= rf_d;
      maddr_q   <= maddr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Requests are decoded from registered state; reset masks them at once
  // so a pending access is dropped in the very cycle reset is seen.
  assign mem_req   = ~reset & ((state_q == ST_FETCH) | (state_q == ST_MEM));
  assign mem_we    = ~reset & (state_q == ST_MEM) & we_q;
  assign mem_addr  = (state_q == ST_MEM) ? maddr_q : pc_q;
  assign mem_wdata = wdata_q;
  assign pc_o      = pc_q;
  assign flags_o   = flags_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule
